// File: rtl/pipeline_ex_stage.sv
// RV64 execute stage: operand select, ALU, branch/jump resolution, iterative
// shift-add multiplier and the EX/MEM pipeline register.
module pipeline_ex_stage #(
  parameter int XLEN       = 64,
  parameter int MUL_CYCLES = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_IDR,
  input  logic [XLEN-1:0] reg_data1_IDR,
  input  logic [XLEN-1:0] reg_data2_IDR,
  input  logic [4:0]      rd_IDR,
  input  logic [XLEN-1:0] imm_IDR,
  input  logic            rf_wr_en_IDR,
  input  logic            do_jump_IDR,
  input  logic            is_branch_IDR,
  input  logic            alu_a_sel_IDR,
  input  logic            alu_b_sel_IDR,
  input  logic [3:0]      alu_ctrl_IDR,
  input  logic [2:0]      BrType_IDR,
  input  logic [1:0]      rf_wr_sel_IDR,
  input  logic [2:0]      dm_rd_ctrl_IDR,
  input  logic [2:0]      dm_wr_ctrl_IDR,
  input  logic            mul_en_IDR,
  input  logic [1:0]      mul_op_IDR,
  output logic            ex_busy,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc_EX,
  output logic [XLEN-1:0] alu_result_EX,
  output logic [XLEN-1:0] rs2_data_EX,
  output logic [XLEN-1:0] pc_plus4_EX,
  output logic [4:0]      rd_EX,
  output logic            rf_wr_en_EX,
  output logic [1:0]      rf_wr_sel_EX,
  output logic [2:0]      dm_rd_ctrl_EX,
  output logic [2:0]      dm_wr_ctrl_EX
);

  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(MUL_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_t;

  mul_state_t          r_state, w_state_nxt;
  logic [CW-1:0]       r_count;
  logic [XLEN-1:0]     r_mcand;
  logic [2*XLEN-1:0]   r_prod;
  logic                r_neg;
  logic [1:0]          r_op;

  logic [XLEN-1:0]     w_a, w_b, w_alu, w_result, w_mul_res;
  logic [SW-1:0]       w_shamt;
  logic                w_cond, w_taken, w_start;
  logic                w_a_neg, w_b_neg;
  logic [XLEN-1:0]     w_a_mag, w_b_mag;
  logic [XLEN:0]       w_sum;
  logic [2*XLEN-1:0]   w_prod_fix;

  assign w_a     = alu_a_sel_IDR ? pc_IDR  : reg_data1_IDR;
  assign w_b     = alu_b_sel_IDR ? imm_IDR : reg_data2_IDR;
  assign w_shamt = w_b[SW-1:0];

  always_comb begin
    w_alu = '0;
    case (alu_ctrl_IDR)
      4'd0:    w_alu = w_a + w_b;
      4'd1:    w_alu = w_a - w_b;
      4'd2:    w_alu = w_a << w_shamt;
      4'd3:    w_alu = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      4'd4:    w_alu = {{(XLEN-1){1'b0}}, (w_a < w_b)};
      4'd5:    w_alu = w_a ^ w_b;
      4'd6:    w_alu = w_a >> w_shamt;
      4'd7:    w_alu = $unsigned($signed(w_a) >>> w_shamt);
      4'd8:    w_alu = w_a | w_b;
      4'd9:    w_alu = w_a & w_b;
      4'd10:   w_alu = w_b;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_cond = 1'b0;
    case (BrType_IDR)
      3'd0:    w_cond = (reg_data1_IDR == reg_data2_IDR);
      3'd1:    w_cond = (reg_data1_IDR != reg_data2_IDR);
      3'd2:    w_cond = ($signed(reg_data1_IDR) <  $signed(reg_data2_IDR));
      3'd3:    w_cond = ($signed(reg_data1_IDR) >= $signed(reg_data2_IDR));
      3'd4:    w_cond = (reg_data1_IDR <  reg_data2_IDR);
      3'd5:    w_cond = (reg_data1_IDR >= reg_data2_IDR);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken        = do_jump_IDR | (is_branch_IDR & w_cond);
  assign redirect_pc    = {w_alu[XLEN-1:1], 1'b0};
  assign redirect_valid = w_taken & ~flush & ~ex_busy;

  // Multiply on magnitudes; the sign is re-applied to the full product in DONE.
  assign w_start = (r_state == S_IDLE) & mul_en_IDR & ~flush;
  assign ex_busy = w_start | (r_state == S_BUSY);
  assign w_a_neg = (mul_op_IDR != 2'd3) & reg_data1_IDR[XLEN-1];
  assign w_b_neg = (mul_op_IDR[1] == 1'b0) & reg_data2_IDR[XLEN-1];
  assign w_a_mag = w_a_neg ? -reg_data1_IDR : reg_data1_IDR;
  assign w_b_mag = w_b_neg ? -reg_data2_IDR : reg_data2_IDR;

  assign w_sum      = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_fix = r_neg ? -r_prod : r_prod;
  assign w_mul_res  = (r_op == 2'd0) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
  assign w_result   = (r_state == S_DONE) ? w_mul_res : w_alu;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_BUSY;
      S_BUSY:  if (r_count == CW'(MUL_CYCLES-1)) w_state_nxt = S_DONE;
      S_DONE:  if (!stall) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_mcand <= '0;
      r_prod  <= '0;
      r_neg   <= 1'b0;
      r_op    <= '0;
    end else if (w_start) begin
      r_count <= '0;
      r_mcand <= w_a_mag;
      r_prod  <= {{XLEN{1'b0}}, w_b_mag};
      r_neg   <= w_a_neg ^ w_b_neg;
      r_op    <= mul_op_IDR;
    end else if (r_state == S_BUSY) begin
      r_count <= r_count + 1'b1;
      r_prod  <= {w_sum, r_prod[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_EX         <= '0;
      alu_result_EX <= '0;
      rs2_data_EX   <= '0;
      pc_plus4_EX   <= '0;
      rd_EX         <= '0;
      rf_wr_en_EX   <= 1'b0;
      rf_wr_sel_EX  <= '0;
      dm_rd_ctrl_EX <= '0;
      dm_wr_ctrl_EX <= '0;
    end else if (flush) begin
      pc_EX         <= '0;
      alu_result_EX <= '0;
      rs2_data_EX   <= '0;
      pc_plus4_EX   <= '0;
      rd_EX         <= '0;
      rf_wr_en_EX   <= 1'b0;
      rf_wr_sel_EX  <= '0;
      dm_rd_ctrl_EX <= '0;
      dm_wr_ctrl_EX <= '0;
    end else if (ex_busy) begin
      rf_wr_en_EX   <= 1'b0;
      dm_rd_ctrl_EX <= '0;
      dm_wr_ctrl_EX <= '0;
    end else if (!stall) begin
      pc_EX         <= pc_IDR;
      alu_result_EX <= w_result;
      rs2_data_EX   <= reg_data2_IDR;
      pc_plus4_EX   <= pc_IDR + XLEN'(4);
      rd_EX         <= rd_IDR;
      rf_wr_en_EX   <= rf_wr_en_IDR;
      rf_wr_sel_EX  <= rf_wr_sel_IDR;
      dm_rd_ctrl_EX <= dm_rd_ctrl_IDR;
      dm_wr_ctrl_EX <= dm_wr_ctrl_IDR;
    end
  end

endmodule

// File: tb/tb_pipeline_ex_stage.sv
// Scoreboard bench for pipeline_ex_stage: random/directed ALU, branch and
// multiply traffic against an arithmetic reference model.
module tb_pipeline_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic [63:0] pc_IDR, reg_data1_IDR, reg_data2_IDR, imm_IDR;
  logic [4:0]  rd_IDR;
  logic        rf_wr_en_IDR, do_jump_IDR, is_branch_IDR, alu_a_sel_IDR, alu_b_sel_IDR;
  logic [3:0]  alu_ctrl_IDR;
  logic [2:0]  BrType_IDR, dm_rd_ctrl_IDR, dm_wr_ctrl_IDR;
  logic [1:0]  rf_wr_sel_IDR, mul_op_IDR;
  logic        mul_en_IDR;
  logic        ex_busy, redirect_valid;
  logic [63:0] redirect_pc, pc_EX, alu_result_EX, rs2_data_EX, pc_plus4_EX;
  logic [4:0]  rd_EX;
  logic        rf_wr_en_EX;
  logic [1:0]  rf_wr_sel_EX;
  logic [2:0]  dm_rd_ctrl_EX, dm_wr_ctrl_EX;

  pipeline_ex_stage #(.XLEN(64), .MUL_CYCLES(64)) dut (
    .clk(clk), .reset(rst_n), .stall(stall), .flush(flush),
    .pc_IDR(pc_IDR), .reg_data1_IDR(reg_data1_IDR), .reg_data2_IDR(reg_data2_IDR),
    .rd_IDR(rd_IDR), .imm_IDR(imm_IDR), .rf_wr_en_IDR(rf_wr_en_IDR),
    .do_jump_IDR(do_jump_IDR), .is_branch_IDR(is_branch_IDR),
    .alu_a_sel_IDR(alu_a_sel_IDR), .alu_b_sel_IDR(alu_b_sel_IDR),
    .alu_ctrl_IDR(alu_ctrl_IDR), .BrType_IDR(BrType_IDR), .rf_wr_sel_IDR(rf_wr_sel_IDR),
    .dm_rd_ctrl_IDR(dm_rd_ctrl_IDR), .dm_wr_ctrl_IDR(dm_wr_ctrl_IDR),
    .mul_en_IDR(mul_en_IDR), .mul_op_IDR(mul_op_IDR),
    .ex_busy(ex_busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc_EX(pc_EX), .alu_result_EX(alu_result_EX), .rs2_data_EX(rs2_data_EX),
    .pc_plus4_EX(pc_plus4_EX), .rd_EX(rd_EX), .rf_wr_en_EX(rf_wr_en_EX),
    .rf_wr_sel_EX(rf_wr_sel_EX), .dm_rd_ctrl_EX(dm_rd_ctrl_EX), .dm_wr_ctrl_EX(dm_wr_ctrl_EX)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc, r1, r2, imm;
    logic [4:0]  rd;
    logic        asel, bsel, jmp, br;
    logic [3:0]  ctl;
    logic [2:0]  bt, dmr, dmw;
    logic [1:0]  wsel;
  } ins_t;

  typedef struct {
    logic [63:0] res, pc, pc4, rs2;
    logic [4:0]  rd;
    logic [1:0]  wsel;
    logic [2:0]  dmr, dmw;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    int unsigned sh;
    logic [63:0] r, ones;
    sh   = int'(b % 64);
    ones = '1;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a << sh;
      4'd3:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd4:  return (a < b) ? 64'd1 : 64'd0;
      4'd5:  return a ^ b;
      4'd6:  return a >> sh;
      4'd7: begin
        r = a >> sh;
        if (a[63] && sh != 0) r = r | ~(ones >> sh);
        return r;
      end
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic ref_cond(input logic [2:0] bt, input logic [63:0] a, input logic [63:0] b);
    case (bt)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return $signed(a) <  $signed(b);
      3'd3: return $signed(a) >= $signed(b);
      3'd4: return a <  b;
      3'd5: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Full-width product of the sign/zero-extended operands.
  function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] xa, xb, p;
    xa = (op != 2'd3) ? {{64{a[63]}}, a} : {64'd0, a};
    xb = (op <  2'd2) ? {{64{b[63]}}, b} : {64'd0, b};
    p  = xa * xb;
    return (op == 2'd0) ? p[63:0] : p[127:64];
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom % 6)
      0: v = 64'd0;
      1: v = '1;
      2: v = 64'd1;
      3: v = 64'h8000_0000_0000_0000;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    i.pc   = {$urandom, $urandom} & ~64'd3;
    i.r1   = pick();
    i.r2   = ($urandom % 4 == 0) ? i.r1 : pick();
    i.imm  = pick();
    i.rd   = 5'($urandom_range(1, 31));
    i.asel = 1'($urandom);
    i.bsel = 1'($urandom);
    i.jmp  = ($urandom % 8 == 0);
    i.br   = 1'($urandom);
    i.ctl  = 4'($urandom);
    i.bt   = 3'($urandom);
    i.wsel = 2'($urandom);
    i.dmr  = 3'($urandom);
    i.dmw  = 3'($urandom);
    return i;
  endfunction

  task automatic apply(input ins_t i);
    pc_IDR = i.pc; reg_data1_IDR = i.r1; reg_data2_IDR = i.r2; imm_IDR = i.imm;
    rd_IDR = i.rd; alu_a_sel_IDR = i.asel; alu_b_sel_IDR = i.bsel;
    do_jump_IDR = i.jmp; is_branch_IDR = i.br; alu_ctrl_IDR = i.ctl;
    BrType_IDR = i.bt; rf_wr_sel_IDR = i.wsel; dm_rd_ctrl_IDR = i.dmr;
    dm_wr_ctrl_IDR = i.dmw; rf_wr_en_IDR = 1'b1;
  endtask

  function automatic exp_t mk_exp(input ins_t i, input logic [63:0] res);
    exp_t e;
    e.res = res; e.pc = i.pc; e.pc4 = i.pc + 64'd4; e.rs2 = i.r2;
    e.rd = i.rd; e.wsel = i.wsel; e.dmr = i.dmr; e.dmw = i.dmw;
    return e;
  endfunction

  // Drive one ALU/branch instruction; leaves time just after the negedge.
  task automatic drive_ins(input ins_t i, input logic st, input logic fl);
    logic [63:0] a, b, res;
    logic        taken;
    @(negedge clk);
    apply(i);
    mul_en_IDR = 1'b0; stall = st; flush = fl;
    #1;
    a     = i.asel ? i.pc : i.r1;
    b     = i.bsel ? i.imm : i.r2;
    res   = ref_alu(i.ctl, a, b);
    taken = i.jmp | (i.br & ref_cond(i.bt, i.r1, i.r2));
    chk("ex_busy_alu", 64'(ex_busy), 64'd0);
    chk("redirect_valid", 64'(redirect_valid), 64'(taken & ~fl));
    chk("redirect_pc", redirect_pc, {res[63:1], 1'b0});
    if (!st && !fl) q.push_back(mk_exp(i, res));
  endtask

  task automatic finish_ins();
    @(posedge clk);
    #2 stall = 1'b1; flush = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pc"}, pc_EX, 64'd0);
    chk({tag, "_alu"}, alu_result_EX, 64'd0);
    chk({tag, "_rs2"}, rs2_data_EX, 64'd0);
    chk({tag, "_pc4"}, pc_plus4_EX, 64'd0);
    chk({tag, "_ctl"}, 64'({rd_EX, rf_wr_en_EX, rf_wr_sel_EX, dm_rd_ctrl_EX, dm_wr_ctrl_EX}), 64'd0);
  endtask

  // flush_at / reset_at: ex_busy cycle index (1 = capture cycle) at which to abort.
  task automatic run_mul(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         input int stall_done, input int flush_at, input int reset_at);
    ins_t i;
    int   busy;
    logic done, aborted;
    i = rand_ins();
    i.r1 = a; i.r2 = b; i.asel = 1'b0; i.bsel = 1'b0; i.jmp = 1'b0; i.br = 1'b0;
    busy = 0; done = 1'b0; aborted = 1'b0;
    @(negedge clk);
    apply(i);
    mul_en_IDR = 1'b1; mul_op_IDR = op; stall = 1'b0; flush = 1'b0;
    for (int c = 0; c < 200 && !done && !aborted; c++) begin
      #1;
      if (ex_busy !== 1'b1) done = 1'b1;
      else begin
        busy++;
        if (flush_at != 0 && busy == flush_at) begin
          flush = 1'b1;
          @(negedge clk);
          flush = 1'b0; mul_en_IDR = 1'b0; stall = 1'b1;
          #1;
          chk("flush_ex_busy", 64'(ex_busy), 64'd0);
          chk_all_zero("flush");
          repeat (3) begin
            @(negedge clk); #1;
            chk("flush_no_product", alu_result_EX, 64'd0);
            chk("flush_no_wen", 64'(rf_wr_en_EX), 64'd0);
          end
          aborted = 1'b1;
        end else if (reset_at != 0 && busy == reset_at) begin
          #2 rst_n = 1'b0;
          #1 chk_all_zero("async_reset");
          @(negedge clk);
          mul_en_IDR = 1'b0; stall = 1'b1;
          #1 rst_n = 1'b1;
          repeat (2) begin
            @(negedge clk); #1;
            chk("reset_no_resume", 64'(ex_busy), 64'd0);
          end
          aborted = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
    if (!aborted) begin
      chk("mul_busy_cycles", 64'(busy), 64'd65);
      chk("mul_reached_done", 64'(done), 64'd1);
      if (stall_done > 0) stall = 1'b1;
      for (int s = 0; s < stall_done; s++) begin
        @(negedge clk); #1;
        chk("done_stall_busy", 64'(ex_busy), 64'd0);
        chk("done_stall_hold_wen", 64'(rf_wr_en_EX), 64'd0);
      end
      stall = 1'b0;
      q.push_back(mk_exp(i, ref_mul(op, a, b)));
      @(posedge clk);
      #2 stall = 1'b1; mul_en_IDR = 1'b0;
    end
  endtask

  // Monitor: any loaded instruction (rf_wr_en_EX after an unstalled edge) must match the queue head.
  initial begin
    logic st, fl;
    exp_t e;
    forever begin
      @(posedge clk);
      st = stall; fl = flush;
      #1;
      if (rf_wr_en_EX === 1'b1 && !st && !fl) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_load actual=alu %h rd %0d expected=no output", alu_result_EX, rd_EX);
        end else begin
          e = q.pop_front();
          chk("mon_alu_result", alu_result_EX, e.res);
          chk("mon_pc", pc_EX, e.pc);
          chk("mon_pc_plus4", pc_plus4_EX, e.pc4);
          chk("mon_rs2", rs2_data_EX, e.rs2);
          chk("mon_ctl", 64'({rd_EX, rf_wr_sel_EX, dm_rd_ctrl_EX, dm_wr_ctrl_EX}),
              64'({e.rd, e.wsel, e.dmr, e.dmw}));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t i;
    rst_n = 1'b0; stall = 1'b1; flush = 1'b0;
    apply(rand_ins());
    rf_wr_en_IDR = 1'b0; mul_en_IDR = 1'b0; mul_op_IDR = 2'd0;
    #1;
    chk_all_zero("reset");
    chk("reset_ex_busy", 64'(ex_busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // ADD with all-ones immediate wraps to 4
    i = rand_ins();
    i.pc = 64'h100; i.r1 = 64'd5; i.imm = '1; i.bsel = 1'b1; i.asel = 1'b0;
    i.ctl = 4'd0; i.rd = 5'd7; i.jmp = 1'b0; i.br = 1'b0;
    drive_ins(i, 1'b0, 1'b0);
    finish_ins();
    @(negedge clk); #1;
    chk("add_result", alu_result_EX, 64'd4);
    chk("add_rd", 64'(rd_EX), 64'd7);
    chk("add_wen", 64'(rf_wr_en_EX), 64'd1);

    // BLT taken, then BLTU not taken on the same operands
    i.pc = 64'h1000; i.r1 = '1; i.r2 = 64'd1; i.imm = 64'h20; i.asel = 1'b1; i.bsel = 1'b1;
    i.ctl = 4'd0; i.bt = 3'd2; i.br = 1'b1; i.jmp = 1'b0;
    drive_ins(i, 1'b0, 1'b0);
    chk("blt_valid", 64'(redirect_valid), 64'd1);
    chk("blt_pc", redirect_pc, 64'h1020);
    finish_ins();
    i.bt = 3'd4;
    drive_ins(i, 1'b0, 1'b0);
    chk("bltu_valid", 64'(redirect_valid), 64'd0);
    finish_ins();

    // JALR clears the target LSB
    i.pc = 64'h3000; i.r1 = 64'h2003; i.imm = 64'd0; i.asel = 1'b0; i.bsel = 1'b1;
    i.ctl = 4'd0; i.jmp = 1'b1; i.br = 1'b0;
    drive_ins(i, 1'b0, 1'b0);
    chk("jalr_valid", 64'(redirect_valid), 64'd1);
    chk("jalr_pc", redirect_pc, 64'h2002);
    finish_ins();
    @(negedge clk); #1;
    chk("jalr_pc_plus4", pc_plus4_EX, 64'h3004);

    run_mul(2'd1, -64'sd2, 64'd3, 0, 0, 0);
    @(negedge clk); #1;
    chk("mulh_const", alu_result_EX, 64'hFFFF_FFFF_FFFF_FFFF);
    run_mul(2'd0, -64'sd2, 64'd3, 0, 0, 0);
    @(negedge clk); #1;
    chk("mul_const", alu_result_EX, 64'hFFFF_FFFF_FFFF_FFFA);
    run_mul(2'd2, 64'h8000_0000_0000_0000, '1, 3, 0, 0);
    run_mul(2'd3, '1, '1, 0, 0, 0);
    run_mul(2'd1, {$urandom, $urandom}, {$urandom, $urandom}, 0, 31, 0);
    run_mul(2'd0, {$urandom, $urandom}, {$urandom, $urandom}, 0, 0, 21);

    for (int n = 0; n < 300; n++) begin
      drive_ins(rand_ins(), ($urandom % 8 == 0), ($urandom % 10 == 0));
      finish_ins();
    end

    for (int n = 0; n < 4; n++)
      run_mul(2'($urandom), pick(), {$urandom, $urandom}, int'($urandom % 3), 0, 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_ex_stage.md
Name: pipeline_ex_stage

Overview:
Execute stage of the 5-stage RV64 pipeline. It sits directly downstream of the register-read (IDR) stage and consumes its latched outputs. The stage selects ALU operands, computes the ALU result, and resolves branches and jumps into a PC redirect. It runs an iterative 64-cycle multiplier for MUL/MULH/MULHSU/MULHU, and latches the results into the EX/MEM pipeline register for the memory stage.

Parameters:
XLEN, 64, datapath width
MUL_CYCLES, 64, multiplier iterations (one bit per cycle); must equal XLEN

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
stall  input  1  hold EX/MEM register (downstream stall)
flush  input  1  clear EX/MEM register and abort multiplier
pc_IDR  input  64  PC of instruction in EX
reg_data1_IDR, reg_data2_IDR  input  64 each  rs1/rs2 operands (already forwarded)
rd_IDR  input  5  destination register
imm_IDR  input  64  immediate
rf_wr_en_IDR, do_jump_IDR, is_branch_IDR, alu_a_sel_IDR, alu_b_sel_IDR  input  1 each  control
alu_ctrl_IDR  input  4  ALU op
BrType_IDR  input  3  branch compare type
rf_wr_sel_IDR  input  2  writeback source select
dm_rd_ctrl_IDR, dm_wr_ctrl_IDR  input  3 each  memory control
mul_en_IDR  input  1  instruction is a multiply
mul_op_IDR  input  2  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
ex_busy  output  1  multiplier occupying EX; upstream must stall
redirect_valid  output  1  taken branch/jump, combinational
redirect_pc  output  64  redirect target, combinational
pc_EX, alu_result_EX, rs2_data_EX, pc_plus4_EX  output  64 each  EX/MEM register
rd_EX  output  5  EX/MEM register
rf_wr_en_EX  output  1  EX/MEM register
rf_wr_sel_EX  output  2  EX/MEM register
dm_rd_ctrl_EX, dm_wr_ctrl_EX  output  3 each  EX/MEM register

Behaviour:
- Clock and reset: one clock clk; reset is asynchronous and active-low. While reset is low, all EX/MEM outputs are 0 and the multiplier FSM is IDLE. Reset mid-multiply aborts the operation with no result.
- Operand A = alu_a_sel ? pc : rs1. Operand B = alu_b_sel ? imm : rs2.
- alu_ctrl encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 pass B.
  - 11-15 produce 0.
  - Shift amount is B[5:0]. Arithmetic wraps mod 2^64.
- BrType compares rs1 vs rs2: 0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU. Codes 6-7 give not-taken.
- taken = do_jump | (is_branch & cond).
- redirect_pc = {alu_result[63:1],1'b0}, which covers JALR LSB clearing.
- redirect_valid = taken & ~flush & ~ex_busy.
- pc_plus4 = pc + 4.
- Multiplier FSM:
  - IDLE: if mul_en & ~flush, capture operand magnitudes and signs per mul_op, go to BUSY with count=0. ex_busy=1 in this cycle.
  - BUSY: one shift-add per cycle; count increments. After count==MUL_CYCLES-1, go to DONE. ex_busy=1.
  - DONE: sign-correct the 128-bit product (negate if the signs differ for signed ops). MUL gives low 64 bits; the other ops give high 64 bits. ex_busy=0.
  - DONE with ~stall: EX/MEM latches the product as alu_result, then go to IDLE. DONE with stall: hold DONE.
  - flush in any state: go to IDLE, result is discarded.
- Multiplier latency: ex_busy is high for exactly 65 cycles (1 IDLE-capture + 64 BUSY). The result is latched at the end of cycle 66 (the DONE cycle).
- While ex_busy=1, the EX/MEM register loads a bubble: rf_wr_en, dm_rd_ctrl and dm_wr_ctrl are 0, other fields are don't-care. Upstream holds the instruction via ex_busy, and DONE does not restart on the still-asserted mul_en.
- EX/MEM register update priority:
  1. flush: all outputs become 0.
  2. ex_busy: bubble.
  3. ~stall: load.
  4. Otherwise: hold.
- Loaded fields: rs2_data_EX = reg_data2. alu_result_EX = ALU result, or the product when in DONE.

Test Plan:
- ADD: rs1=5, imm=0xFFFFFFFFFFFFFFFF, alu_b_sel=1, alu_ctrl=0 -> next edge alu_result_EX=4, rd_EX and rf_wr_en_EX copied.
- BLT: rs1=-1, rs2=1, BrType=2, is_branch=1, pc=0x1000, imm=0x20, alu_a_sel=1, alu_b_sel=1 -> redirect_valid=1, redirect_pc=0x1020. With BrType=4 (BLTU), redirect_valid=0.
- JALR: rs1=0x2003, imm=0, do_jump=1 -> redirect_pc=0x2002, pc_plus4_EX=pc+4.
- MULH: mul_en=1, mul_op=1, rs1=-2, rs2=3 -> ex_busy high 65 cycles, bubbles emitted meanwhile, then alu_result_EX=0xFFFFFFFFFFFFFFFF. With mul_op=0, alu_result_EX=0xFFFFFFFFFFFFFFFA.
- Flush at BUSY cycle 30 -> ex_busy=0 next cycle, all EX/MEM outputs 0, no product ever latched.
- stall held during DONE for 3 cycles -> outputs unchanged, ex_busy=0, product latched on the first edge after stall drops. Reset asserted asynchronously mid-BUSY -> outputs 0 immediately.
